mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the SoC's single-port synchronous RAM between the CPU instruction-fetch port and its load/store port. Each cycle it selects at most one requester, drives the RAM, and returns read data one cycle later with a per-port valid pulse. Sits between `cpu` and the RAM inside `soc`, replacing the direct CPU-to-memory wiring.

## Interface
Parameters:
- `ADDR_W`, 10, word-address width (RAM depth = 2^ADDR_W words)
- `DATA_W`, 32, data width; byte strobes = DATA_W/8

Ports:
- `clk`  in  1  system clock, rising edge
- `resetn`  in  1  asynchronous, active-low reset
- `i_req`  in  1  instruction fetch request (read only)
- `i_addr`  in  ADDR_W  fetch word address
- `i_gnt`  out  1  fetch request accepted this cycle
- `i_rvalid`  out  1  fetch data valid on `i_rdata`
- `i_rdata`  out  DATA_W  fetch read data
- `d_req`  in  1  data request
- `d_we`  in  1  1 = write, 0 = read
- `d_wstrb`  in  DATA_W/8  byte write enables (ignored on read)
- `d_addr`  in  ADDR_W  data word address
- `d_wdata`  in  DATA_W  write data
- `d_gnt`  out  1  data request accepted this cycle
- `d_rvalid`  out  1  data read data valid
- `d_rdata`  out  DATA_W  data read data
- `mem_en`  out  1  RAM access enable
- `mem_we`  out  DATA_W/8  RAM byte write enables
- `mem_addr`  out  ADDR_W  RAM address
- `mem_wdata`  out  DATA_W  RAM write data
- `mem_rdata`  in  DATA_W  RAM read data, valid one cycle after a read with `mem_en`

## Operation
- Handshake: request accepted in the cycle where `x_req && x_gnt`. Requester holds `x_req`, address, and write fields stable until accepted; arbiter never revokes an accepted grant.
- At most one of `i_gnt`/`d_gnt` high per cycle; a grant only when the matching `req` is high.
- Winner drives `mem_en=1`, `mem_addr`; for a data write `mem_we=d_wstrb`, `mem_wdata=d_wdata`; otherwise `mem_we=0`. No winner: `mem_en=0`, `mem_we=0`.
- Read accept registers an owner flag (`rd_pend`, `rd_owner`). Next cycle the owner's `x_rvalid` pulses high for exactly one cycle. Writes produce no `rvalid`.
- `i_rdata` and `d_rdata` are both wired to `mem_rdata`; only `x_rvalid` qualifies them.
- Throughput: one access per cycle, back-to-back reads allowed; a response and a new accept may occur in the same cycle.
- Arbitration state: `last_d` register (1 = data won the last contended or uncontended grant). Updated on every grant.
- Reset (async, `resetn=0`): `rd_pend=0`, `last_d=0`; all grants, `rvalid`, `mem_en`, `mem_we` forced to 0 while reset is asserted. A read accepted in the cycle before reset assertion never produces `rvalid`.

## Timing
- `x_gnt` and all `mem_*` outputs are combinational from `x_req`, request fields, and `last_d`; no flops in that path.
- `x_rvalid` is registered: latency exactly 1 cycle from accept edge.
- No combinational path from `x_req` to `x_rvalid`.
- Only one request → that requester is granted in the same cycle regardless of policy.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined: when both request, the port that did not win last is granted (`last_d=0` → data, else instruction); first contention after reset goes to data.
- Not defined: fixed priority, data always wins contention; `i_gnt` only in cycles with `d_req=0`. `last_d` is still maintained but unused.

## Test plan
- Reset: hold `resetn=0` with `i_req=d_req=1` → `i_gnt=d_gnt=0`, `mem_en=0`, `mem_we=0`, both `rvalid=0`.
- Single fetch: `i_req=1`, `i_addr=0x010`, RAM[0x010]=0x00000013 → `i_gnt=1`, `mem_addr=0x010` same cycle; next cycle `i_rvalid=1`, `i_rdata=0x00000013`, `d_rvalid=0`.
- Byte write: RAM[0x020]=0x11223344; data write `d_wstrb=4'b0011`, `d_wdata=0xAABBCCDD` → `mem_we=4'b0011`, no `d_rvalid`; subsequent data read of 0x020 → `d_rdata=0x1122CCDD` with `d_rvalid` one cycle after accept.
- Round-robin (macro on): both requesting continuously for 6 cycles after reset → grant order D,I,D,I,D,I; each `rvalid` lands on the correct port one cycle later.
- Fixed priority (macro off): both requesting for 4 cycles → `d_gnt=1`, `i_gnt=0` every cycle; drop `d_req` → `i_gnt=1` that same cycle.
- Reset mid-read: accept a fetch, assert `resetn=0` before the next rising edge → `i_rvalid` stays 0; after release, a new fetch completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one single-port synchronous RAM between CPU fetch and load/store ports.
// Optional `MEM_ARB_ROUND_ROBIN_EN selects round-robin contention; default is fixed data priority.
module mem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_wstrb,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int STRB_W = DATA_W / 8;

  logic rd_pend;
  logic rd_owner;
  logic last_d;
  logic pick_i;
  logic pick_d;
  logic rd_acc;
  logic last_d_nxt;
  logic rd_owner_nxt;

  // Grant selection is purely combinational so a lone requester wins in the same cycle.
  always_comb begin
    pick_i = 1'b0;
    pick_d = 1'b0;
    if (resetn) begin
      if (i_req && d_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        pick_d = ~last_d;
`else
        pick_d = 1'b1;
`endif
        pick_i = ~pick_d;
      end else begin
        pick_i = i_req;
        pick_d = d_req;
      end
    end
  end

  assign i_gnt = pick_i;
  assign d_gnt = pick_d;

  always_comb begin
    mem_en    = pick_i | pick_d;
    mem_addr  = pick_d ? d_addr : i_addr;
    mem_we    = (pick_d && d_we) ? d_wstrb : {STRB_W{1'b0}};
    mem_wdata = d_wdata;
  end

  always_comb begin
    rd_acc       = pick_i | (pick_d & ~d_we);
    rd_owner_nxt = rd_acc ? pick_d : rd_owner;
    last_d_nxt   = (pick_i | pick_d) ? pick_d : last_d;
  end

  // Accept edge -> response cycle: remember who owns the read in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_pend  <= 1'b0;
      rd_owner <= 1'b0;
      last_d   <= 1'b0;
    end else begin
      rd_pend  <= rd_acc;
      rd_owner <= rd_owner_nxt;
      last_d   <= last_d_nxt;
    end
  end

  assign i_rvalid = rd_pend & ~rd_owner;
  assign d_rvalid = rd_pend &  rd_owner;
  assign i_rdata  = mem_rdata;
  assign d_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed steps push expected read data, a monitor pops on rvalid.
module tb_mem_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          resetn;
  logic          i_req, i_gnt, i_rvalid;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid;
  logic [SW-1:0] d_wstrb;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          mem_en;
  logic [SW-1:0] mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t iq[$];
  exp_t dq[$];
  exp_t mon_e;

  logic [DW-1:0] ram [0:(1<<AW)-1];

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .resetn(resetn),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_wstrb(d_wstrb), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Behavioural single-port RAM: byte-enabled write, read-first, one-cycle read latency.
  initial begin : ram_model
    logic [DW-1:0] w;
    for (int k = 0; k < (1 << AW); k++) ram[k] = 32'hA500_0000 | k;
    ram[10'h010] = 32'h0000_0013;
    ram[10'h020] = 32'h1122_3344;
    forever begin
      @(posedge clk);
      if (mem_en) begin
        w = ram[mem_addr];
        for (int b = 0; b < SW; b++)
          if (mem_we[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
        ram[mem_addr] <= w;
        mem_rdata     <= ram[mem_addr];
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every response must arrive exactly in its due cycle on its own port.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (iq.size() > 0 && iq[0].due == cyc) begin
        mon_e = iq.pop_front();
        chk("i_rvalid", i_rvalid, 1);
        chk("i_rdata", i_rdata, mon_e.data);
      end else if (i_rvalid) begin
        chk("i_rvalid spurious", i_rvalid, 0);
      end
      if (dq.size() > 0 && dq[0].due == cyc) begin
        mon_e = dq.pop_front();
        chk("d_rvalid", d_rvalid, 1);
        chk("d_rdata", d_rdata, mon_e.data);
      end else if (d_rvalid) begin
        chk("d_rvalid spurious", d_rvalid, 0);
      end
    end
  end

  task automatic step(input logic ir, input logic [AW-1:0] ia,
                      input logic dr, input logic dw, input logic [SW-1:0] ds,
                      input logic [AW-1:0] da, input logic [DW-1:0] wd,
                      input logic eig, input logic edg,
                      input logic [DW-1:0] eir, input logic [DW-1:0] edr);
    @(negedge clk);
    i_req = ir; i_addr = ia;
    d_req = dr; d_we = dw; d_wstrb = ds; d_addr = da; d_wdata = wd;
    #1;
    chk("i_gnt", i_gnt, eig);
    chk("d_gnt", d_gnt, edg);
    chk("mem_en", mem_en, eig | edg);
    chk("mem_we", mem_we, (edg && dw) ? ds : '0);
    if (eig | edg) chk("mem_addr", mem_addr, edg ? da : ia);
    if (edg && dw) chk("mem_wdata", mem_wdata, wd);
    if (eig) iq.push_back('{data: eir, due: cyc + 1});
    if (edg && !dw) dq.push_back('{data: edr, due: cyc + 1});
  endtask

  task automatic idle();
    step(0, '0, 0, 0, '0, '0, '0, 0, 0, '0, '0);
  endtask

  initial begin
    logic sel;
    resetn = 1'b0;
    i_req = 1'b1; i_addr = 10'h010;
    d_req = 1'b1; d_we = 1'b0; d_wstrb = '0; d_addr = 10'h020; d_wdata = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset i_gnt", i_gnt, 0);
    chk("reset d_gnt", d_gnt, 0);
    chk("reset mem_en", mem_en, 0);
    chk("reset mem_we", mem_we, 0);
    chk("reset i_rvalid", i_rvalid, 0);
    chk("reset d_rvalid", d_rvalid, 0);
    @(negedge clk);
    resetn = 1'b1; i_req = 1'b0; d_req = 1'b0;

    step(1, 10'h010, 0, 0, '0, '0, '0, 1, 0, 32'h0000_0013, '0);
    idle();
    step(0, '0, 1, 1, 4'b0011, 10'h020, 32'hAABB_CCDD, 0, 1, '0, '0);
    step(0, '0, 1, 0, '0, 10'h020, '0, 0, 1, '0, 32'h1122_CCDD);
    step(1, 10'h040, 0, 0, '0, '0, '0, 1, 0, 32'hA500_0040, '0);
    step(0, '0, 1, 0, '0, 10'h041, '0, 0, 1, '0, 32'hA500_0041);
    idle();

    @(negedge clk);
    resetn = 1'b0;
    iq.delete(); dq.delete();
    @(negedge clk);
    resetn = 1'b1;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    for (int k = 0; k < 6; k++) begin
      sel = k[0];
      step(1, 10'h040, 1, 0, '0, 10'h080, '0, sel, ~sel, 32'hA500_0040, 32'hA500_0080);
    end
`else
    for (int k = 0; k < 4; k++)
      step(1, 10'h040, 1, 0, '0, 10'h080, '0, 0, 1, '0, 32'hA500_0080);
    step(1, 10'h040, 0, 0, '0, '0, '0, 1, 0, 32'hA500_0040, '0);
`endif
    idle();

    step(1, 10'h010, 0, 0, '0, '0, '0, 1, 0, 32'h0000_0013, '0);
    resetn = 1'b0;
    iq.delete(); dq.delete();
    #1;
    chk("mid-reset i_gnt", i_gnt, 0);
    chk("mid-reset mem_en", mem_en, 0);
    @(negedge clk);
    #1;
    chk("mid-reset i_rvalid", i_rvalid, 0);
    @(negedge clk);
    resetn = 1'b1; i_req = 1'b0;

    step(1, 10'h010, 0, 0, '0, '0, '0, 1, 0, 32'h0000_0013, '0);
    step(0, '0, 1, 0, '0, 10'h020, '0, 0, 1, '0, 32'h1122_CCDD);
    idle();
    idle();
    @(negedge clk);
    chk("responses outstanding", iq.size() + dq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
